delay_line_var: RTL and testbench

- Parametrised, runtime-programmable delay line: next generation of the fixed W×L shift-register delay used across the GPSDO datapath.
- Adds:
  - async active-low reset
  - clock enable
  - synchronous flush
  - per-sample valid tracking
  - delay selectable per clock (1..L) with clamping and an error flag
  - a fill tracker (`primed`) reporting when the selected tap holds data written since the last reset, flush or delay change
- Used for aligning PPS/timestamp and sample streams whose relative latency is configured by software.

---
 rtl/delay_line_var_if.sv | 27 ++
 rtl/delay_line_var.sv | 104 ++++++++++
 tb/tb_delay_line_var.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/delay_line_var_if.sv
// Bundles the stream-side signals of the variable delay line.
// The master drives the input stream and delay select; the slave
// (the delay line itself) returns the delayed stream and status.
interface delay_line_var_if #(
   parameter int W  = 1,
   parameter int DW = 4
);
   logic          ce;
   logic          flush;
   logic [DW-1:0] dly;
   logic [W-1:0]  d;
   logic          d_vld;
   logic [W-1:0]  q;
   logic          q_vld;
   logic          primed;
   logic          dly_err;

   modport master (
      output ce, flush, dly, d, d_vld,
      input  q, q_vld, primed, dly_err
   );

   modport slave (
      input  ce, flush, dly, d, d_vld,
      output q, q_vld, primed, dly_err
   );
endinterface

// File: rtl/delay_line_var.sv
// Runtime-programmable W x L delay line with clock enable, synchronous
// flush, per-sample valid tracking, clamped delay select with an error
// flag, and a fill tracker that reports when the selected tap holds
// data written since the last reset, flush or delay change.
module delay_line_var #(
   parameter int W  = 1,
   parameter int L  = 8,
   parameter int DW = 4
) (
   input logic              clk,
   input logic              rst_n,
   delay_line_var_if.slave  bus
);

   localparam logic [DW-1:0] L_DW = DW'(L);

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [W-1:0]  r [L];
   logic [L-1:0]  v;
   logic [DW-1:0] dly_r;
   logic          dly_err_r;
   logic [DW-1:0] dly_clamp;
   logic          dly_change;
   logic [DW-1:0] cnt;
   logic [0:0]    state;

   // Clamp the requested delay into 1..L and detect a change of tap.
   always_comb begin
      dly_clamp = bus.dly;
      if (bus.dly == '0) begin
         dly_clamp = DW'(1);
      end else if (bus.dly > L_DW) begin
         dly_clamp = L_DW;
      end
      dly_change = (dly_clamp != dly_r);
   end

   // Delay select and error flag are sampled every clock, independent of ce.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dly_r     <= L_DW;
         dly_err_r <= 1'b0;
      end else begin
         dly_r     <= dly_clamp;
         dly_err_r <= (bus.dly == '0) || (bus.dly > L_DW);
      end
   end

   // Data and valid shift chain; flush clears it and suppresses the write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < L; i++) begin
            r[i] <= '0;
            v[i] <= 1'b0;
         end
      end else if (bus.flush) begin
         for (int i = 0; i < L; i++) begin
            r[i] <= '0;
            v[i] <= 1'b0;
         end
      end else if (bus.ce) begin
         r[0] <= bus.d;
         v[0] <= bus.d_vld;
         for (int i = 1; i < L; i++) begin
            r[i] <= r[i-1];
            v[i] <= v[i-1];
         end
      end
   end

   // Fill tracker: count ce-edges since restart until the selected tap is reached.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_FILL;
         cnt   <= '0;
      end else if (bus.flush || dly_change) begin
         state <= ST_FILL;
         cnt   <= '0;
      end else if (bus.ce && (state == ST_FILL)) begin
         cnt <= cnt + 1'b1;
         if (cnt == (dly_r - 1'b1)) begin
            state <= ST_RUN;
         end
      end
   end

   // Tap mux selecting stage dly_r-1, written as a compare loop so the
   // select width need not match the stage index width.
   always_comb begin
      bus.q     = '0;
      bus.q_vld = 1'b0;
      for (int i = 0; i < L; i++) begin
         if (dly_r == DW'(i + 1)) begin
            bus.q     = r[i];
            bus.q_vld = v[i];
         end
      end
      bus.primed  = (state == ST_RUN);
      bus.dly_err = dly_err_r;
   end

endmodule

// File: tb/tb_delay_line_var.sv
// Directed self-checking bench for delay_line_var: a table of per-cycle
// vectors for the main stream, plus hand sequences for async reset,
// refill at the maximum delay and the single-stage configuration.
module tb_delay_line_var;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   delay_line_var_if #(.W(8), .DW(4)) bus ();
   delay_line_var_if #(.W(4), .DW(1)) bus1 ();

   delay_line_var #(.W(8), .L(8), .DW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   delay_line_var #(.W(4), .L(1), .DW(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   typedef struct {
      logic       ce;
      logic       flush;
      logic [3:0] dly;
      logic [7:0] d;
      logic       d_vld;
      logic [7:0] q;
      logic       q_vld;
      logic       primed;
      logic       dly_err;
   } vec_t;

   vec_t vecs [33];

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input logic ce, input logic flush, input logic [3:0] dly,
                               input logic [7:0] d, input logic d_vld, input logic [7:0] q,
                               input logic q_vld, input logic primed, input logic dly_err);
      vec_t t;
      t.ce = ce; t.flush = flush; t.dly = dly; t.d = d; t.d_vld = d_vld;
      t.q = q; t.q_vld = q_vld; t.primed = primed; t.dly_err = dly_err;
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic ce, input logic flush, input logic [3:0] dly,
                                input logic [7:0] d, input logic d_vld);
      bus.ce = ce; bus.flush = flush; bus.dly = dly; bus.d = d; bus.d_vld = d_vld;
      @(posedge clk);
      #1;
   endtask

   task automatic checkAll(input string tag, input logic [7:0] q, input logic q_vld,
                           input logic primed, input logic dly_err);
      checkOutput({tag, " q"}, 32'(bus.q), 32'(q));
      checkOutput({tag, " q_vld"}, 32'(bus.q_vld), 32'(q_vld));
      checkOutput({tag, " primed"}, 32'(bus.primed), 32'(primed));
      checkOutput({tag, " dly_err"}, 32'(bus.dly_err), 32'(dly_err));
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // ce, flush, dly, d, d_vld | q, q_vld, primed, dly_err
      vecs[0]  = mk(0, 0,  8,  0, 0,   0, 0, 0, 0);
      vecs[1]  = mk(0, 0,  3,  0, 0,   0, 0, 0, 0);
      vecs[2]  = mk(1, 0,  3,  1, 1,   0, 0, 0, 0);
      vecs[3]  = mk(1, 0,  3,  2, 1,   0, 0, 0, 0);
      vecs[4]  = mk(1, 0,  3,  3, 1,   1, 1, 1, 0);
      vecs[5]  = mk(1, 0,  3,  4, 1,   2, 1, 1, 0);
      vecs[6]  = mk(1, 0,  3,  5, 1,   3, 1, 1, 0);
      vecs[7]  = mk(0, 0,  3, 99, 0,   3, 1, 1, 0);
      vecs[8]  = mk(0, 0,  3, 99, 0,   3, 1, 1, 0);
      vecs[9]  = mk(0, 0,  3, 99, 0,   3, 1, 1, 0);
      vecs[10] = mk(0, 0,  3, 99, 0,   3, 1, 1, 0);
      vecs[11] = mk(1, 0,  3,  6, 1,   4, 1, 1, 0);
      vecs[12] = mk(1, 0,  3,  7, 0,   5, 1, 1, 0);
      vecs[13] = mk(1, 0,  3,  8, 1,   6, 1, 1, 0);
      vecs[14] = mk(1, 0,  3,  9, 1,   7, 0, 1, 0);
      vecs[15] = mk(1, 0,  3, 10, 1,   8, 1, 1, 0);
      vecs[16] = mk(1, 1,  3, 11, 1,   0, 0, 0, 0);
      vecs[17] = mk(1, 0,  3, 12, 1,   0, 0, 0, 0);
      vecs[18] = mk(1, 0,  3, 13, 1,   0, 0, 0, 0);
      vecs[19] = mk(1, 0,  3, 14, 1,  12, 1, 1, 0);
      vecs[20] = mk(0, 0,  5,  0, 0,   0, 0, 0, 0);
      vecs[21] = mk(1, 0,  5, 15, 1,   0, 0, 0, 0);
      vecs[22] = mk(1, 0,  5, 16, 1,  12, 1, 0, 0);
      vecs[23] = mk(1, 0,  5, 17, 1,  13, 1, 0, 0);
      vecs[24] = mk(1, 0,  5, 18, 1,  14, 1, 0, 0);
      vecs[25] = mk(1, 0,  5, 19, 1,  15, 1, 1, 0);
      vecs[26] = mk(0, 0,  2,  0, 0,  18, 1, 0, 0);
      vecs[27] = mk(1, 0,  2, 20, 1,  19, 1, 0, 0);
      vecs[28] = mk(1, 0,  2, 21, 1,  20, 1, 1, 0);
      vecs[29] = mk(0, 0,  0,  0, 0,  21, 1, 0, 1);
      vecs[30] = mk(0, 0,  1,  0, 0,  21, 1, 0, 0);
      vecs[31] = mk(0, 0, 12,  0, 0,  14, 1, 0, 1);
      vecs[32] = mk(0, 0,  5,  0, 0,  17, 1, 0, 0);

      rst_n = 1'b0;
      bus.ce = 0; bus.flush = 0; bus.dly = 4'd8; bus.d = '0; bus.d_vld = 0;
      bus1.ce = 0; bus1.flush = 0; bus1.dly = 1'b1; bus1.d = '0; bus1.d_vld = 0;
      #12;
      checkAll("reset", 8'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 33; i++) begin
         applyStimulus(vecs[i].ce, vecs[i].flush, vecs[i].dly, vecs[i].d, vecs[i].d_vld);
         checkAll($sformatf("vec%0d", i), vecs[i].q, vecs[i].q_vld, vecs[i].primed, vecs[i].dly_err);
      end

      // Set the error flag and load data, then reset asynchronously between edges.
      applyStimulus(1, 0, 4'd0, 8'd50, 1);
      checkAll("pre_rst", 8'd50, 1'b1, 1'b0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checkAll("async_rst", 8'd0, 1'b0, 1'b0, 1'b0);
      #1;
      rst_n = 1'b1;

      // Refill at the maximum delay without changing it: primed on the 8th ce-edge.
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1, 0, 4'd8, 8'(100 + k), 1);
         checkOutput($sformatf("refill%0d primed", k), 32'(bus.primed), (k == 7) ? 32'd1 : 32'd0);
         checkOutput($sformatf("refill%0d q_vld", k), 32'(bus.q_vld), (k == 7) ? 32'd1 : 32'd0);
      end
      checkOutput("refill q", 32'(bus.q), 32'd100);
      applyStimulus(1, 0, 4'd8, 8'd108, 1);
      checkOutput("refill next q", 32'(bus.q), 32'd101);

      // Single-stage line: q follows d after one ce-edge; dly=0 only flags an error.
      bus1.ce = 1; bus1.dly = 1'b1; bus1.d = 4'd5; bus1.d_vld = 1;
      @(posedge clk);
      #1;
      checkOutput("l1 q", 32'(bus1.q), 32'd5);
      checkOutput("l1 q_vld", 32'(bus1.q_vld), 32'd1);
      checkOutput("l1 primed", 32'(bus1.primed), 32'd1);
      checkOutput("l1 dly_err", 32'(bus1.dly_err), 32'd0);
      bus1.ce = 0; bus1.dly = 1'b0; bus1.d = 4'd9;
      @(posedge clk);
      #1;
      checkOutput("l1 err q", 32'(bus1.q), 32'd5);
      checkOutput("l1 err primed", 32'(bus1.primed), 32'd1);
      checkOutput("l1 err dly_err", 32'(bus1.dly_err), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
